instruction_memory: RTL and testbench

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

---
 rtl/instruction_memory.sv | 67 ++++++
 tb/tb_instruction_memory.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_memory
//  Description : Word-addressed instruction store with a combinational read
//                port, synchronous program-load write port, out-of-range
//                fault flag and asynchronous clear of every implemented word.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int DataWidth = 16,
    parameter int AddrBits  = 16,
    parameter int Depth     = 256
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [AddrBits-1:0]  ReadAddr,
    output logic [DataWidth-1:0] ReadData,
    output logic                 AddrFault,
    input  logic                 WriteEn,
    input  logic [AddrBits-1:0]  WriteAddr,
    input  logic [DataWidth-1:0] WriteData
);

    // Index width into the implemented words; at least one bit so that the
    // slices below stay legal for a degenerate single-word memory.
    localparam int c_IdxBits = (Depth > 1) ? $clog2(Depth) : 1;

    // Depth held one bit wider than the address so Depth == 2**AddrBits
    // is representable and the range test never wraps.
    localparam logic [AddrBits:0] c_Depth = Depth[AddrBits:0];

    logic [DataWidth-1:0] r_mem [Depth];

    logic                 w_readInRange;
    logic                 w_writeInRange;
    logic [c_IdxBits-1:0] w_readIdx;
    logic [c_IdxBits-1:0] w_writeIdx;

    // Full-width range checks: addresses at or beyond Depth never alias.
    assign w_readInRange  = ({1'b0, ReadAddr}  < c_Depth);
    assign w_writeInRange = ({1'b0, WriteAddr} < c_Depth);
    assign w_readIdx      = ReadAddr[c_IdxBits-1:0];
    assign w_writeIdx     = WriteAddr[c_IdxBits-1:0];

    // Storage: asynchronous clear of every word, otherwise in-range load.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (WriteEn && w_writeInRange) begin
            r_mem[w_writeIdx] <= WriteData;
        end
    end

    // Combinational fetch: zero data while in reset or out of range; the
    // fault flag depends only on the address.
    always_comb begin
        ReadData  = '0;
        AddrFault = !w_readInRange;
        if (w_readInRange && !Reset) begin
            ReadData = r_mem[w_readIdx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_memory
//  Description : Directed self-checking bench for instruction_memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_memory;

    localparam int c_DataWidth = 16;
    localparam int c_AddrBits  = 16;
    localparam int c_Depth     = 256;

    logic                   Clk;
    logic                   Reset;
    logic [c_AddrBits-1:0]  ReadAddr;
    logic [c_DataWidth-1:0] ReadData;
    logic                   AddrFault;
    logic                   WriteEn;
    logic [c_AddrBits-1:0]  WriteAddr;
    logic [c_DataWidth-1:0] WriteData;

    int r_checks = 0;
    int r_errors = 0;

    instruction_memory #(
        .DataWidth (c_DataWidth),
        .AddrBits  (c_AddrBits),
        .Depth     (c_Depth)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ReadAddr  (ReadAddr),
        .ReadData  (ReadData),
        .AddrFault (AddrFault),
        .WriteEn   (WriteEn),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData)
    );

    // 10 ns clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic checkResult(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        r_checks++;
        if (observed !== expected) begin
            r_errors++;
            $display("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Apply an address and check data/fault after the combinational settle
    task automatic readCheck(input string tag, input logic [15:0] addr,
                             input logic [15:0] expData, input logic expFault);
        ReadAddr = addr;
        #1;
        checkResult({tag, "_data"}, {16'h0, ReadData}, {16'h0, expData});
        checkResult({tag, "_fault"}, {31'h0, AddrFault}, {31'h0, expFault});
    endtask

    // One write cycle, driven from the falling edge
    task automatic writeWord(input logic [15:0] addr, input logic [15:0] data);
        @(negedge Clk);
        WriteEn   = 1'b1;
        WriteAddr = addr;
        WriteData = data;
        @(posedge Clk);
        #1;
        WriteEn   = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        WriteEn   = 1'b0;
        WriteAddr = '0;
        WriteData = '0;
        ReadAddr  = '0;

        // In reset: zero data, fault still address-driven
        #2;
        readCheck("rst_rd5", 16'd5, 16'h0000, 1'b0);
        readCheck("rst_rd300", 16'd300, 16'h0000, 1'b1);
        @(negedge Clk);
        Reset = 1'b0;

        // Post-reset contents are zero
        readCheck("init0", 16'd0, 16'h0000, 1'b0);
        #4;
        readCheck("init1", 16'd1, 16'h0000, 1'b0);
        #4;
        readCheck("init2", 16'd2, 16'h0000, 1'b0);

        // Program load, then clockless reads
        writeWord(16'd0, 16'hA001);
        writeWord(16'd1, 16'hB002);
        writeWord(16'd2, 16'hC003);
        readCheck("ld0", 16'd0, 16'hA001, 1'b0);
        readCheck("ld1", 16'd1, 16'hB002, 1'b0);
        readCheck("ld2", 16'd2, 16'hC003, 1'b0);

        // Read-during-write: old word before the edge, new word after
        @(negedge Clk);
        ReadAddr  = 16'd1;
        WriteEn   = 1'b1;
        WriteAddr = 16'd1;
        WriteData = 16'h1234;
        #1;
        checkResult("rdw_before", {16'h0, ReadData}, 32'h0000_B002);
        @(posedge Clk);
        #1;
        WriteEn = 1'b0;
        checkResult("rdw_after", {16'h0, ReadData}, 32'h0000_1234);

        // Range boundary
        readCheck("oor256", 16'd256, 16'h0000, 1'b1);
        readCheck("oorFFFF", 16'hFFFF, 16'h0000, 1'b1);
        readCheck("last_empty", 16'd255, 16'h0000, 1'b0);
        writeWord(16'd255, 16'h5A5A);
        readCheck("last_wr", 16'd255, 16'h5A5A, 1'b0);
        writeWord(16'd256, 16'hDEAD);
        readCheck("noalias0", 16'd0, 16'hA001, 1'b0);
        readCheck("noalias256", 16'd256, 16'h0000, 1'b1);

        // Reset mid-cycle with a concurrent write
        @(negedge Clk);
        WriteEn   = 1'b1;
        WriteAddr = 16'd2;
        WriteData = 16'h7777;
        ReadAddr  = 16'd0;
        #1;
        Reset = 1'b1;
        #1;
        checkResult("rst_immediate", {16'h0, ReadData}, 32'h0);
        readCheck("rst_fault", 16'd300, 16'h0000, 1'b1);
        @(posedge Clk);
        #1;
        readCheck("rst_wr_blocked", 16'd2, 16'h0000, 1'b0);
        @(negedge Clk);
        WriteEn = 1'b0;
        Reset   = 1'b0;
        readCheck("cleared0", 16'd0, 16'h0000, 1'b0);
        readCheck("cleared2", 16'd2, 16'h0000, 1'b0);
        readCheck("cleared255", 16'd255, 16'h0000, 1'b0);

        // First write after reset works
        writeWord(16'd3, 16'hBEEF);
        readCheck("post_rst_wr", 16'd3, 16'hBEEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
